// File: rtl/player_link_pkg.sv
// Shared types and packet helpers for the inter-board player-state link.
// The receiver on the peer board imports this package as well.
package player_link_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hA5;
  localparam int         PKT_BYTES  = 6;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // b0 is the first byte on the wire
  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] b4;
    logic [7:0] b5;
  } player_pkt_t;

  function automatic logic [7:0] pkt_checksum(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic [7:0] b4
  );
    return b1 ^ b2 ^ b3 ^ b4;
  endfunction

  function automatic player_pkt_t pkt_build(
    input logic [1:0] id,
    input logic [2:0] gstate,
    input logic [3:0] pstate,
    input logic [1:0] dir,
    input logic [8:0] x,
    input logic [8:0] y
  );
    player_pkt_t p;
    p.b0 = PKT_HEADER;
    p.b1 = {id, dir, pstate};
    p.b2 = x[7:0];
    p.b3 = y[7:0];
    p.b4 = {gstate, 3'b000, y[8], x[8]};
    p.b5 = pkt_checksum(p.b1, p.b2, p.b3, p.b4);
    return p;
  endfunction

  function automatic logic [7:0] pkt_byte(
    input player_pkt_t p,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = p.b0;
      3'd1:    b = p.b1;
      3'd2:    b = p.b2;
      3'd3:    b = p.b3;
      3'd4:    b = p.b4;
      3'd5:    b = p.b5;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/player_state_tx_if.sv
// Byte handshake between the frame sequencer and the UART shifter.
// The shifter also reports its state and an end-of-activity pulse.
interface player_state_tx_if;
  import player_link_pkg::*;

  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       done;
  tx_state_t  state;

  modport master (
    output valid,
    output data,
    input  ready,
    input  done,
    input  state
  );

  modport slave (
    input  valid,
    input  data,
    output ready,
    output done,
    output state
  );

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 shifter, LSB first, with valid/ready handshake.
// Accepting a byte on the last stop cycle gives back-to-back bytes.
module uart_byte_tx
  import player_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic clk,
  input  logic rst,
  player_state_tx_if.slave link,
  output logic tx
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  logic [TW-1:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        done;
  logic        tick;

  assign tick = (timer == TMAX);

  assign link.state = state;
  assign link.done  = done;
  assign link.ready = (state == IDLE) ||
                      (state == STOP && tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      done  <= 1'b0;
      timer <= (state == IDLE || tick) ? '0
                                       : timer + TW'(1);
      unique case (state)
        IDLE: begin
          if (link.valid) begin
            shreg <= link.data;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (link.valid) begin
              shreg <= link.data;
              state <= START;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so reset forces the line high immediately
  always_comb begin
    tx = 1'b1;
    if (state == START) tx = 1'b0;
    if (state == DATA)  tx = shreg[0];
  end

endmodule

// File: rtl/player_state_tx.sv
// Player-state link transmitter: vsync-fall snapshot, 6-byte framing,
// byte sequencing into the UART shifter, saturating drop counter.
module player_state_tx
  import player_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  vsync,
  input  logic [1:0]            local_player_ID,
  input  logic [2:0]            game_state,
  input  logic [3:0]            player_state,
  input  logic [1:0]            player_direction,
  input  logic [8:0]            player_loc_x,
  input  logic [8:0]            player_loc_y,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DROP_CNT_W-1:0] frames_dropped
);

  player_state_tx_if link ();

  logic        s1, s2, s3;
  logic        fall;
  logic        idle;
  logic        accept;
  logic        drop;
  logic [2:0]  byte_idx;
  player_pkt_t pkt_q;

  assign fall   = s3 & ~s2;
  assign idle   = (link.state == IDLE);
  assign accept = fall & enable & idle;
  assign drop   = fall & enable & ~idle;

  // Header is constant, so byte 0 goes out before the shadow settles
  assign link.valid = accept || (byte_idx != 3'd0);
  assign link.data  = accept ? PKT_HEADER
                             : pkt_byte(pkt_q, byte_idx);

  assign busy       = ~idle;
  assign frame_done = link.done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= vsync;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_q    <= '0;
      byte_idx <= '0;
    end else begin
      if (accept) begin
        pkt_q <= pkt_build(local_player_ID, game_state,
                           player_state, player_direction,
                           player_loc_x, player_loc_y);
        byte_idx <= 3'd1;
      end else if (link.ready && byte_idx != 3'd0) begin
        byte_idx <= (byte_idx == 3'(PKT_BYTES - 1))
                    ? 3'd0 : byte_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frames_dropped <= '0;
    end else if (drop && frames_dropped != '1) begin
      frames_dropped <= frames_dropped + DROP_CNT_W'(1);
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clock),
    .rst  (reset),
    .link (link.slave),
    .tx   (tx)
  );

endmodule

// File: tb/tb_player_state_tx.sv
// Directed bench for player_state_tx with CLKS_PER_BIT=4.
// Frames are decoded from the tx line at mid-bit sample points.
module tb_player_state_tx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       vsync;
  logic [1:0] pid;
  logic [2:0] gstate;
  logic [3:0] pstate;
  logic [1:0] dir;
  logic [8:0] loc_x;
  logic [8:0] loc_y;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] frames_dropped;

  int n_vec;
  int n_err;

  logic [47:0] frm;
  int          bcyc;
  int          dones;
  logic        fr_ok;
  int          bad_busy;
  int          bad_tx;
  int          w;

  player_state_tx #(
    .CLKS_PER_BIT(4),
    .DROP_CNT_W  (8)
  ) dut (
    .clock           (clk),
    .reset           (rst),
    .enable          (enable),
    .vsync           (vsync),
    .local_player_ID (pid),
    .game_state      (gstate),
    .player_state    (pstate),
    .player_direction(dir),
    .player_loc_x    (loc_x),
    .player_loc_y    (loc_y),
    .tx              (tx),
    .busy            (busy),
    .frame_done      (frame_done),
    .frames_dropped  (frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // act: 1 vsync fall, 2 x:=5, 3 enable:=0, 4 async reset
  task automatic run_frame(
    input  int          act,
    input  int          at,
    output logic [47:0] f,
    output int          nb,
    output int          nd,
    output logic        ok
  );
    logic [59:0] line;
    int k;
    f    = '0;
    nb   = 0;
    nd   = 0;
    ok   = 1'b0;
    line = '0;
    vsync = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 10);
    vsync = 1'b1;
    if (!busy) begin
      check("frame_start", 64'(busy), 64'd1);
      return;
    end
    for (int c = 0; c < 260; c++) begin
      if (busy) nb++;
      if (frame_done) nd++;
      if (c % 4 == 2 && c < 240) line[c / 4] = tx;
      if (c == at) begin
        if (act == 1) vsync = 1'b0;
        if (act == 2) loc_x = 9'd5;
        if (act == 3) enable = 1'b0;
        if (act == 4) begin
          rst = 1'b1;
          #1;
          check("arst_tx", 64'(tx), 64'd1);
          check("arst_busy", 64'(busy), 64'd0);
          check("arst_done", 64'(frame_done), 64'd0);
          check("arst_drop", 64'(frames_dropped), 64'd0);
        end
      end
      if (act == 1 && c == at + 4) vsync = 1'b1;
      if (act == 4 && c == at + 3) rst = 1'b0;
      @(negedge clk);
    end
    ok = 1'b1;
    for (int j = 0; j < 6; j++) begin
      f[47 - 8 * j -: 8] = line[10 * j + 1 +: 8];
      if (line[10 * j] !== 1'b0) ok = 1'b0;
      if (line[10 * j + 9] !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    repeat (5) @(negedge clk);
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    enable = 1'b1;
    vsync  = 1'b1;
    pid    = 2'd2;
    dir    = 2'd1;
    pstate = 4'd3;
    loc_x  = 9'd300;
    loc_y  = 9'd240;
    gstate = 3'd2;

    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_drop", 64'(frames_dropped), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(0, -1, frm, bcyc, dones, fr_ok);
    check("basic_bytes", 64'(frm), 64'hA5932CF0410E);
    check("basic_busy", 64'(bcyc), 64'd240);
    check("basic_done", 64'(dones), 64'd1);
    check("basic_fmt", 64'(fr_ok), 64'd1);
    check("basic_drop", 64'(frames_dropped), 64'd0);

    run_frame(1, 50, frm, bcyc, dones, fr_ok);
    check("drop_bytes", 64'(frm), 64'hA5932CF0410E);
    check("drop_busy", 64'(bcyc), 64'd240);
    check("drop_done", 64'(dones), 64'd1);
    check("drop_cnt", 64'(frames_dropped), 64'd1);

    run_frame(2, 45, frm, bcyc, dones, fr_ok);
    check("shadow_bytes", 64'(frm), 64'hA5932CF0410E);
    run_frame(0, -1, frm, bcyc, dones, fr_ok);
    check("shadow_next", 64'(frm), 64'hA59305F04026);
    check("shadow_fmt", 64'(fr_ok), 64'd1);

    run_frame(3, 100, frm, bcyc, dones, fr_ok);
    check("en_mid_bytes", 64'(frm), 64'hA59305F04026);
    check("en_mid_busy", 64'(bcyc), 64'd240);
    check("en_mid_done", 64'(dones), 64'd1);

    vsync    = 1'b0;
    bad_busy = 0;
    bad_tx   = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy) bad_busy++;
      if (!tx) bad_tx++;
      if (c == 4) vsync = 1'b1;
    end
    check("gate_busy", 64'(bad_busy), 64'd0);
    check("gate_tx", 64'(bad_tx), 64'd0);
    check("gate_drop", 64'(frames_dropped), 64'd1);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(4, 125, frm, bcyc, dones, fr_ok);
    check("arst_nodone", 64'(dones), 64'd0);
    run_frame(0, -1, frm, bcyc, dones, fr_ok);
    check("post_rst_bytes", 64'(frm), 64'hA59305F04026);
    check("post_rst_done", 64'(dones), 64'd1);
    check("post_rst_drop", 64'(frames_dropped), 64'd0);

    // fall lands on the last STOP cycle: dropped
    run_frame(1, 237, frm, bcyc, dones, fr_ok);
    check("edge_a_busy", 64'(bcyc), 64'd240);
    check("edge_a_drop", 64'(frames_dropped), 64'd1);

    // fall lands on the first IDLE cycle: accepted
    run_frame(1, 238, frm, bcyc, dones, fr_ok);
    check("edge_b_busy", 64'(bcyc), 64'd259);
    check("edge_b_drop", 64'(frames_dropped), 64'd1);
    wait_idle();

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      vsync = ~vsync;
    end
    vsync = 1'b1;
    wait_idle();
    check("sat_drop", 64'(frames_dropped), 64'd255);

    w = 0;
    run_frame(1, 60, frm, bcyc, dones, fr_ok);
    check("sat_hold", 64'(frames_dropped), 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
